serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Bit-serial multi-bit adder controller. It sequences one shared 1-bit adder cell, built from two half-adder stages plus a carry flop, across a WIDTH-bit operand pair, one bit per clock, LSB first.
- Provides a start/busy/done handshake so lab top levels (comparator, ALU experiments) can request additions without instantiating a WIDTH-wide ripple adder.
- Result and carry-out are registered and held until the next completion.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request pulse or level; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- sum  output  WIDTH  registered result of a+b+cin.
- cout  output  1  registered carry-out.
- busy  output  1  high while a serial operation is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE; sum=0, cout=0, busy=0, done=0.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Any in-flight operation is discarded; no done pulse is produced.
  - The first start after release is sampled at the first rising edge with rst_n=1.
- State machine: two states, IDLE and RUN.
- IDLE, start=1 at rising edge E:
  - Load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, acc<=0.
  - Move to RUN; busy=1 from E.
- IDLE, start=0: hold all state; sum and cout keep their last values.
- RUN, each rising edge:
  - Stage 1 half adder: p=a_sh[0]^b_sh[0], g1=a_sh[0]&b_sh[0].
  - Stage 2 half adder: s=p^carry, g2=p&carry.
  - carry<=g1|g2.
  - acc shifts right with s inserted at MSB; a_sh and b_sh shift right; cnt<=cnt+1.
- RUN, edge where cnt==WIDTH-1 (bit WIDTH-1 processed):
  - sum<={s,acc[WIDTH-1:1]}, i.e. the final shifted acc.
  - cout<=g1|g2.
  - done<=1, busy<=0, state<=IDLE.
- Latency: accepting edge E, result edge E+WIDTH. done is high for exactly the cycle after E+WIDTH. busy is high for exactly WIDTH cycles.
- done is a single-cycle pulse and deasserts at the next edge regardless of start.
- start while busy=1 is ignored: no queuing, no effect on the operation.
- Changes to a, b or cin after the accepting edge have no effect.
- Back-to-back operation: start=1 in the cycle done is high (state already IDLE) is accepted at that edge. Throughput is one addition per WIDTH+1 cycles when start is held high.
- sum and cout change only at a result edge or reset; they never show partial values.
- WIDTH=1: a single RUN cycle; done follows the accepting edge by 1 cycle.
- Counter width: max(1, clog2(WIDTH)); cnt never exceeds WIDTH-1.

Test Plan:
- Reset, then WIDTH=4, a=4'h5, b=4'h3, cin=0, start one cycle:
  - busy high 4 cycles, then done pulse.
  - sum=4'h8, cout=0.
- a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1.
- a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1 (decimal 31).
- Start a=4'h2, b=4'h2; two cycles later pulse start with a=4'h7, b=4'h7 (ignored) and change a to 4'h9 -> result sum=4'h4, cout=0; exactly one done pulse.
- Hold start=1 with a=4'h1, b=4'h1 then a=4'h6, b=4'h3 presented at the first done cycle:
  - done pulses 5 cycles apart.
  - sums 4'h2 then 4'h9; busy low only during the done cycle.
- Start a=4'hA, b=4'h5, assert rst_n=0 mid-RUN (after 2 cycles):
  - Immediately busy=0, done=0, sum=0, cout=0.
  - After release, with no start, outputs stay 0 and no done pulse appears.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial WIDTH-bit adder controller. A single 1-bit adder cell, built from
// two half adders and a carry flop, is stepped across the operand pair one
// bit per clock, LSB first. Callers see a start/busy/done handshake. The
// result is registered and held until the next completion.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request (pulse or level), sampled only while idle
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   sum    out  WIDTH  registered a+b+cin (low WIDTH bits)
//   cout   out  1      registered carry-out
//   busy   out  1      high while a serial operation is in progress
//   done   out  1      one-cycle completion pulse
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_done;

    // FSM control strobes
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_last;

    // Adder cell
    logic             w_p;
    logic             w_g1;
    logic             w_s;
    logic             w_g2;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_acc_nxt;

    // -----------------------------------------------------------------------
    // Shared 1-bit adder cell: two cascaded half adders. The first combines
    // the current operand bits, the second folds in the stored carry. Both
    // generate terms can never be high together, so OR is a full carry.
    // -----------------------------------------------------------------------
    assign w_p         = r_a_sh[0] ^ r_b_sh[0];
    assign w_g1        = r_a_sh[0] & r_b_sh[0];
    assign w_s         = w_p ^ r_carry;
    assign w_g2        = w_p & r_carry;
    assign w_carry_nxt = w_g1 | w_g2;

    // The accumulator fills from the MSB side, so after WIDTH shifts the
    // first (LSB) result bit has arrived at bit 0.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_nxt = w_s;
        end else begin : g_acc_wn
            assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == CNT_LAST);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and datapath strobes. start is only looked at in IDLE,
    // which is what makes requests during an operation disappear silently.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand shifters, carry flop, bit counter and accumulator
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_acc   <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry_nxt;
            // Park the counter at zero on the last bit so it never reaches
            // WIDTH, even when WIDTH is not a power of two.
            r_cnt   <= w_last ? '0 : (r_cnt + CNT_ONE);
        end
    end

    // -----------------------------------------------------------------------
    // Result registers: written only on the result edge, so partial sums are
    // never visible. done is rewritten every cycle, giving a single pulse.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_finish) begin
                r_sum  <= w_acc_nxt;
                r_cout <= w_carry_nxt;
            end
            r_done <= w_finish;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = (r_state == S_RUN);
    assign done = r_done;

endmodule
